// File: rtl/cft_runmon_pkg.sv
// Shared status codes and FSM state encodings for the CFT run monitor.
package cft_runmon_pkg;

    localparam logic [1:0] ST_RUNNING = 2'b00;
    localparam logic [1:0] ST_HALTED  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_FAIL    = 2'b11;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } runmon_state_t;

endpackage

// File: rtl/cft_runmon_filter.sv
// Consecutive-low-sample debouncer for the active-low halt line; 'halted' pulses
// combinationally on the edge that takes the HALT_FILT-th consecutive low sample.
module cft_runmon_filter #(
    parameter int HALT_FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic srst,
    input  logic nhalt,
    output logic halted
);

    localparam int               CNT_W    = (HALT_FILT > 1) ? $clog2(HALT_FILT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_FILT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count consecutive low samples, clamped at HALT_FILT-1; any high sample restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (srst || nhalt) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign halted = ~nhalt & (r_cnt == CNT_LAST);

endmodule

// File: rtl/cft_run_monitor.sv
// Run supervisor: holds the CPU in reset, then watches for fail/halt/watchdog.
// Optional `CFT_RUNMON_CYCCNT_EN exposes the RUN-cycle counter on run_cycles.
module cft_run_monitor
    import cft_runmon_pkg::*;
#(
    parameter int RESET_CYCLES    = 100,
    parameter int TIMEOUT_W       = 24,
    parameter int DEFAULT_TIMEOUT = 100000,
    parameter int NCHAN           = 4,
    parameter int HALT_FILT       = 3
) (
    input  logic                 clk1,
    input  logic                 reset,
    output logic                 nreset_drv,
    input  logic                 nhalt,
    input  logic [NCHAN-1:0]     fail_in,
    input  logic                 timeout_ld,
    input  logic [TIMEOUT_W-1:0] timeout_val,
    output logic                 done,
    output logic [1:0]           status,
    output logic [NCHAN-1:0]     fail_mask
`ifdef CFT_RUNMON_CYCCNT_EN
    ,
    output logic [TIMEOUT_W-1:0] run_cycles
`endif
);

    localparam int                HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

    runmon_state_t        r_state, w_state_nxt;
    logic [HOLD_W-1:0]    r_hold_cnt, w_hold_nxt;
    logic [TIMEOUT_W-1:0] r_run_cnt, w_run_nxt, w_run_inc;
    logic [TIMEOUT_W-1:0] r_limit, w_limit_nxt;
    logic [1:0]           r_status, w_status_nxt;
    logic [NCHAN-1:0]     r_fail_mask, w_mask_nxt;
    logic                 r_done, r_nreset;
    logic                 w_halted, w_timeout;

    cft_runmon_filter #(
        .HALT_FILT (HALT_FILT)
    ) u_filter (
        .clk    (clk1),
        .rst    (reset),
        .srst   (r_state != S_RUN),
        .nhalt  (nhalt),
        .halted (w_halted)
    );

    assign w_run_inc = (&r_run_cnt) ? r_run_cnt : r_run_cnt + TIMEOUT_W'(1);
    assign w_timeout = (r_limit != '0) && (r_run_cnt == r_limit - TIMEOUT_W'(1));

    // State register.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_state <= S_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counters and result capture; exit priority is fail > halt > timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold_cnt;
        w_run_nxt    = r_run_cnt;
        w_limit_nxt  = r_limit;
        w_status_nxt = r_status;
        w_mask_nxt   = r_fail_mask;
        case (r_state)
            S_HOLD: begin
                if (timeout_ld) begin
                    w_limit_nxt = timeout_val;
                end else begin
                    w_limit_nxt = r_limit;
                end
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            S_RUN: begin
                w_run_nxt = w_run_inc;
                if (|fail_in) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_FAIL;
                    w_mask_nxt   = fail_in;
                end else if (w_halted) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_HALTED;
                end else if (w_timeout) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_TIMEOUT;
                end else begin
                    w_state_nxt  = S_RUN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase
    end

    // Datapath registers; outputs are registered from the next-state decision.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_hold_cnt  <= '0;
            r_run_cnt   <= '0;
            r_limit     <= TIMEOUT_W'(DEFAULT_TIMEOUT);
            r_status    <= ST_RUNNING;
            r_fail_mask <= '0;
            r_done      <= 1'b0;
            r_nreset    <= 1'b0;
        end else begin
            r_hold_cnt  <= w_hold_nxt;
            r_run_cnt   <= w_run_nxt;
            r_limit     <= w_limit_nxt;
            r_status    <= w_status_nxt;
            r_fail_mask <= w_mask_nxt;
            r_done      <= (w_state_nxt == S_DONE);
            r_nreset    <= (w_state_nxt != S_HOLD);
        end
    end

    assign nreset_drv = r_nreset;
    assign done       = r_done;
    assign status     = r_status;
    assign fail_mask  = r_fail_mask;
`ifdef CFT_RUNMON_CYCCNT_EN
    assign run_cycles = r_run_cnt;
`endif

endmodule
